// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit. It latches the instruction word and steps through
// FETCH/DECODE/EXEC/MEM/WB/TRAP, driving the datapath controls for the current state.
//
// state  | meaning
// FETCH  | wait for imem_ready, latch instruction (wait-timeout to TRAP)
// DECODE | classify opcode; illegal goes to TRAP, or retires as a NOP
// EXEC   | ALU operation; branches and jumps load the PC here
// MEM    | data access, held until dmem_ready (wait-timeout to TRAP)
// WB     | regfile write; non-jumps load PC+4
// TRAP   | one-cycle trap pulse; PC loads the trap vector
module multicycle_control_unit #(
   parameter int MEM_TIMEOUT     = 16,
   parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] Instruction,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   input  logic        BrEq,
   input  logic        BrLT,
   output logic [3:0]  ALUop,
   output logic [2:0]  ImmSel,
   output logic        ASel,
   output logic        BSel,
   output logic        BrUn,
   output logic [1:0]  PCSel,
   output logic        PCWrite,
   output logic        IRWrite,
   output logic        wEn,
   output logic [1:0]  WBSel,
   output logic        MemEn,
   output logic        MemRW,
   output logic        trap,
   output logic [2:0]  state
);
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

   state_t        cur;
   logic [31:0]   ir;
   logic [CW-1:0] cnt;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       f7b5, rd_zero;
   logic       is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
   logic       is_jump, illegal, taken;
   logic [3:0] alu_f3;
   logic       unused_ir_bits;

   assign opcode   = ir[6:0];
   assign funct3   = ir[14:12];
   assign f7b5     = ir[30];
   assign rd_zero  = (ir[11:7] == 5'd0);
   assign unused_ir_bits = ^{ir[31], ir[29:15]};

   assign is_r     = (opcode == 7'b0110011);
   assign is_i     = (opcode == 7'b0010011);
   assign is_ld    = (opcode == 7'b0000011);
   assign is_st    = (opcode == 7'b0100011);
   assign is_br    = (opcode == 7'b1100011);
   assign is_jal   = (opcode == 7'b1101111);
   assign is_jalr  = (opcode == 7'b1100111);
   assign is_lui   = (opcode == 7'b0110111);
   assign is_auipc = (opcode == 7'b0010111);
   assign is_jump  = is_jal | is_jalr;
   assign illegal  = !(is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc)
                     || (is_br && funct3[2:1] == 2'b01);

   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:         taken = BrEq;
         3'b001:         taken = !BrEq;
         3'b100, 3'b110: taken = BrLT;
         3'b101, 3'b111: taken = !BrLT;
         default:        taken = 1'b0;
      endcase
   end

   // funct7[5] selects SUB only for R-type; for shifts it selects SRA in both forms
   always_comb begin
      alu_f3 = 4'd0;
      case (funct3)
         3'b000:  alu_f3 = (is_r && f7b5) ? 4'd1 : 4'd0;
         3'b001:  alu_f3 = 4'd2;
         3'b010:  alu_f3 = 4'd3;
         3'b011:  alu_f3 = 4'd4;
         3'b100:  alu_f3 = 4'd5;
         3'b101:  alu_f3 = f7b5 ? 4'd7 : 4'd6;
         3'b110:  alu_f3 = 4'd8;
         default: alu_f3 = 4'd9;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cur <= S_FETCH;
         ir  <= '0;
         cnt <= '0;
      end else begin
         case (cur)
            S_FETCH: begin
               if (imem_ready) begin
                  ir  <= Instruction;
                  cnt <= '0;
                  cur <= S_DECODE;
               end else if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  cur <= S_TRAP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DECODE: begin
               if (illegal) cur <= TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
               else         cur <= S_EXEC;
            end
            S_EXEC: begin
               cnt <= '0;
               if (is_br)              cur <= S_FETCH;
               else if (is_ld | is_st) cur <= S_MEM;
               else                    cur <= S_WB;
            end
            S_MEM: begin
               if (dmem_ready) begin
                  cnt <= '0;
                  cur <= is_st ? S_FETCH : S_WB;
               end else if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  cur <= S_TRAP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: cur <= S_FETCH;
         endcase
      end
   end

   assign state = cur;

   // Controls are gated by reset_n so every output is 0 while reset is held
   always_comb begin
      ALUop   = 4'd0;
      ImmSel  = 3'd0;
      ASel    = 1'b0;
      BSel    = 1'b0;
      BrUn    = 1'b0;
      PCSel   = 2'd0;
      PCWrite = 1'b0;
      IRWrite = 1'b0;
      wEn     = 1'b0;
      WBSel   = 2'd0;
      MemEn   = 1'b0;
      MemRW   = 1'b0;
      trap    = 1'b0;
      if (reset_n) begin
         if (cur inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            ALUop  = (is_r | is_i) ? alu_f3 : (is_lui ? 4'd10 : 4'd0);
            ImmSel = is_st ? 3'd1 : is_br ? 3'd2 : (is_lui | is_auipc) ? 3'd3 : is_jal ? 3'd4 : 3'd0;
            ASel   = is_br | is_jal | is_auipc;
            BSel   = !is_r && !illegal;
            BrUn   = is_br & funct3[1];
         end
         case (cur)
            S_FETCH:  IRWrite = imem_ready;
            S_DECODE: PCWrite = illegal && !TRAP_ON_ILLEGAL;
            S_EXEC: begin
               if (is_br) begin
                  PCWrite = 1'b1;
                  PCSel   = taken ? 2'd1 : 2'd0;
               end else if (is_jump) begin
                  PCWrite = 1'b1;
                  PCSel   = 2'd1;
               end
            end
            S_MEM: begin
               MemEn   = 1'b1;
               MemRW   = is_st;
               PCWrite = dmem_ready && is_st;
            end
            S_WB: begin
               wEn     = !rd_zero;
               WBSel   = is_ld ? 2'd0 : (is_jump ? 2'd2 : 2'd1);
               PCWrite = !is_jump;
            end
            S_TRAP: begin
               trap    = 1'b1;
               PCWrite = 1'b1;
               PCSel   = 2'd2;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: two instances share stimulus, one trapping
// on illegal instructions and one retiring them as NOPs.
module tb_multicycle_control_unit;
   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] Instruction;
   logic        imem_ready, dmem_ready, BrEq, BrLT;

   logic [3:0] ALUop;   logic [2:0] ImmSel; logic ASel, BSel, BrUn;
   logic [1:0] PCSel;   logic PCWrite, IRWrite, wEn; logic [1:0] WBSel;
   logic       MemEn, MemRW, trap; logic [2:0] state;

   logic [3:0] n_ALUop; logic [2:0] n_ImmSel; logic n_ASel, n_BSel, n_BrUn;
   logic [1:0] n_PCSel; logic n_PCWrite, n_IRWrite, n_wEn; logic [1:0] n_WBSel;
   logic       n_MemEn, n_MemRW, n_trap; logic [2:0] n_state;

   int total = 0;
   int bad   = 0;
   logic [31:0] got, exp;

   always #5 clock = ~clock;

   multicycle_control_unit #(.MEM_TIMEOUT(16), .TRAP_ON_ILLEGAL(1'b1)) u_trap (
      .clock(clock), .reset_n(reset_n), .Instruction(Instruction),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .BrEq(BrEq), .BrLT(BrLT),
      .ALUop(ALUop), .ImmSel(ImmSel), .ASel(ASel), .BSel(BSel), .BrUn(BrUn),
      .PCSel(PCSel), .PCWrite(PCWrite), .IRWrite(IRWrite), .wEn(wEn), .WBSel(WBSel),
      .MemEn(MemEn), .MemRW(MemRW), .trap(trap), .state(state));

   multicycle_control_unit #(.MEM_TIMEOUT(16), .TRAP_ON_ILLEGAL(1'b0)) u_nop (
      .clock(clock), .reset_n(reset_n), .Instruction(Instruction),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .BrEq(BrEq), .BrLT(BrLT),
      .ALUop(n_ALUop), .ImmSel(n_ImmSel), .ASel(n_ASel), .BSel(n_BSel), .BrUn(n_BrUn),
      .PCSel(n_PCSel), .PCWrite(n_PCWrite), .IRWrite(n_IRWrite), .wEn(n_wEn), .WBSel(n_WBSel),
      .MemEn(n_MemEn), .MemRW(n_MemRW), .trap(n_trap), .state(n_state));

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Presents one instruction for a single FETCH cycle; returns in DECODE.
   task automatic fetch(input logic [31:0] instr);
      Instruction = instr;
      imem_ready  = 1'b1;
      tick();
      imem_ready  = 1'b0;
   endtask

   task automatic test_reset;
      @(posedge clock); #1;
      imem_ready = 1'b1;
      #1;
      got = 32'({state, IRWrite, PCWrite, trap, MemEn, wEn}); exp = 32'({3'd0, 5'b00000});
      total++; if (got !== exp) begin bad++; $display("FAIL reset_outputs got=%h exp=%h", got, exp); end
      reset_n = 1'b1;
      #1;
      got = 32'({state, IRWrite}); exp = 32'({3'd0, 1'b1});
      total++; if (got !== exp) begin bad++; $display("FAIL reset_release_fetch got=%h exp=%h", got, exp); end
      imem_ready = 1'b0;
      tick();
      got = 32'(state); exp = 32'd0;
      total++; if (got !== exp) begin bad++; $display("FAIL reset_hold_fetch got=%h exp=%h", got, exp); end
   endtask

   task automatic test_add;
      fetch(32'h0000_0033);
      got = 32'(state); exp = 32'd1;
      total++; if (got !== exp) begin bad++; $display("FAIL add_decode got=%h exp=%h", got, exp); end
      tick();
      got = 32'({state, ALUop, ASel, BSel, PCWrite}); exp = 32'({3'd2, 4'd0, 1'b0, 1'b0, 1'b0});
      total++; if (got !== exp) begin bad++; $display("FAIL add_exec got=%h exp=%h", got, exp); end
      tick();
      got = 32'({state, wEn, WBSel, ALUop, PCWrite, PCSel}); exp = 32'({3'd4, 1'b0, 2'd1, 4'd0, 1'b1, 2'd0});
      total++; if (got !== exp) begin bad++; $display("FAIL add_wb got=%h exp=%h", got, exp); end
      tick();
      got = 32'({state, PCWrite}); exp = 32'({3'd0, 1'b0});
      total++; if (got !== exp) begin bad++; $display("FAIL add_back_to_fetch got=%h exp=%h", got, exp); end
   endtask

   task automatic test_branch(input logic [31:0] instr, input logic eq, input logic lt,
                              input logic exp_brun, input logic [1:0] exp_pcsel);
      BrEq = eq;
      BrLT = lt;
      fetch(instr);
      tick();
      got = 32'({state, BrUn, ImmSel, ASel, BSel, PCWrite, PCSel});
      exp = 32'({3'd2, exp_brun, 3'd2, 1'b1, 1'b1, 1'b1, exp_pcsel});
      total++; if (got !== exp) begin bad++; $display("FAIL branch_exec instr=%h got=%h exp=%h", instr, got, exp); end
      tick();
      got = 32'({state, PCWrite, wEn}); exp = 32'({3'd0, 1'b0, 1'b0});
      total++; if (got !== exp) begin bad++; $display("FAIL branch_next instr=%h got=%h exp=%h", instr, got, exp); end
      BrEq = 1'b0;
      BrLT = 1'b0;
   endtask

   task automatic test_alu(input logic [31:0] instr, input logic [3:0] exp_alu,
                           input logic exp_bsel, input logic exp_wen);
      fetch(instr);
      tick();
      got = 32'({state, ALUop, BSel}); exp = 32'({3'd2, exp_alu, exp_bsel});
      total++; if (got !== exp) begin bad++; $display("FAIL alu_exec instr=%h got=%h exp=%h", instr, got, exp); end
      tick();
      got = 32'({state, wEn, WBSel, PCWrite, PCSel}); exp = 32'({3'd4, exp_wen, 2'd1, 1'b1, 2'd0});
      total++; if (got !== exp) begin bad++; $display("FAIL alu_wb instr=%h got=%h exp=%h", instr, got, exp); end
      tick();
   endtask

   task automatic test_jump;
      fetch(32'h0000_00EF);
      tick();
      got = 32'({state, ASel, ImmSel, ALUop, PCWrite, PCSel}); exp = 32'({3'd2, 1'b1, 3'd4, 4'd0, 1'b1, 2'd1});
      total++; if (got !== exp) begin bad++; $display("FAIL jal_exec got=%h exp=%h", got, exp); end
      tick();
      got = 32'({state, wEn, WBSel, PCWrite}); exp = 32'({3'd4, 1'b1, 2'd2, 1'b0});
      total++; if (got !== exp) begin bad++; $display("FAIL jal_wb got=%h exp=%h", got, exp); end
      tick();
      fetch(32'h0000_80E7);
      tick();
      got = 32'({state, ASel, BSel, ImmSel, PCWrite, PCSel}); exp = 32'({3'd2, 1'b0, 1'b1, 3'd0, 1'b1, 2'd1});
      total++; if (got !== exp) begin bad++; $display("FAIL jalr_exec got=%h exp=%h", got, exp); end
      tick();
      got = 32'({state, wEn, WBSel, PCWrite}); exp = 32'({3'd4, 1'b1, 2'd2, 1'b0});
      total++; if (got !== exp) begin bad++; $display("FAIL jalr_wb got=%h exp=%h", got, exp); end
      tick();
   endtask

   task automatic test_load;
      dmem_ready = 1'b0;
      fetch(32'h0000_2083);
      tick();
      got = 32'({state, ImmSel, BSel, ALUop}); exp = 32'({3'd2, 3'd0, 1'b1, 4'd0});
      total++; if (got !== exp) begin bad++; $display("FAIL load_exec got=%h exp=%h", got, exp); end
      tick();
      for (int i = 0; i < 3; i++) begin
         got = 32'({state, MemEn, MemRW, PCWrite}); exp = 32'({3'd3, 1'b1, 1'b0, 1'b0});
         total++; if (got !== exp) begin bad++; $display("FAIL load_wait cyc=%0d got=%h exp=%h", i, got, exp); end
         tick();
      end
      dmem_ready = 1'b1;
      #1;
      got = 32'({state, MemEn, MemRW, PCWrite}); exp = 32'({3'd3, 1'b1, 1'b0, 1'b0});
      total++; if (got !== exp) begin bad++; $display("FAIL load_ready got=%h exp=%h", got, exp); end
      tick();
      dmem_ready = 1'b0;
      got = 32'({state, wEn, WBSel, PCWrite, PCSel, MemEn}); exp = 32'({3'd4, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0});
      total++; if (got !== exp) begin bad++; $display("FAIL load_wb got=%h exp=%h", got, exp); end
      tick();
   endtask

   task automatic test_store_timeout;
      dmem_ready = 1'b0;
      fetch(32'h0000_0023);
      tick();
      got = 32'({state, ImmSel, BSel}); exp = 32'({3'd2, 3'd1, 1'b1});
      total++; if (got !== exp) begin bad++; $display("FAIL store_exec got=%h exp=%h", got, exp); end
      tick();
      for (int i = 0; i < 16; i++) begin
         got = 32'({state, MemEn, MemRW}); exp = 32'({3'd3, 1'b1, 1'b1});
         total++; if (got !== exp) begin bad++; $display("FAIL store_wait cyc=%0d got=%h exp=%h", i, got, exp); end
         tick();
      end
      got = 32'({state, trap, PCSel, PCWrite, MemEn, wEn}); exp = 32'({3'd5, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0});
      total++; if (got !== exp) begin bad++; $display("FAIL store_trap got=%h exp=%h", got, exp); end
      tick();
      got = 32'({state, trap, PCWrite}); exp = 32'({3'd0, 1'b0, 1'b0});
      total++; if (got !== exp) begin bad++; $display("FAIL store_after_trap got=%h exp=%h", got, exp); end
   endtask

   task automatic test_fetch_timeout;
      Instruction = 32'h0000_0033;
      imem_ready  = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      got = 32'(state); exp = 32'd0;
      total++; if (got !== exp) begin bad++; $display("FAIL fetch_wait15 got=%h exp=%h", got, exp); end
      imem_ready = 1'b1;
      #1;
      got = 32'({state, IRWrite}); exp = 32'({3'd0, 1'b1});
      total++; if (got !== exp) begin bad++; $display("FAIL fetch_ready_last got=%h exp=%h", got, exp); end
      tick();
      imem_ready = 1'b0;
      got = 32'({state, trap}); exp = 32'({3'd1, 1'b0});
      total++; if (got !== exp) begin bad++; $display("FAIL fetch_ready_wins got=%h exp=%h", got, exp); end
      tick(); tick(); tick();
      for (int i = 0; i < 16; i++) tick();
      got = 32'({state, trap, PCSel, PCWrite}); exp = 32'({3'd5, 1'b1, 2'd2, 1'b1});
      total++; if (got !== exp) begin bad++; $display("FAIL fetch_timeout_trap got=%h exp=%h", got, exp); end
      tick();
   endtask

   task automatic test_illegal;
      fetch(32'h0000_007F);
      got = 32'({state, PCWrite}); exp = 32'({3'd1, 1'b0});
      total++; if (got !== exp) begin bad++; $display("FAIL illegal_decode_trapcfg got=%h exp=%h", got, exp); end
      got = 32'({n_state, n_PCWrite, n_PCSel, n_wEn}); exp = 32'({3'd1, 1'b1, 2'd0, 1'b0});
      total++; if (got !== exp) begin bad++; $display("FAIL illegal_decode_nopcfg got=%h exp=%h", got, exp); end
      tick();
      got = 32'({state, trap, PCWrite, PCSel, MemEn, wEn}); exp = 32'({3'd5, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0});
      total++; if (got !== exp) begin bad++; $display("FAIL illegal_trap got=%h exp=%h", got, exp); end
      got = 32'({n_state, n_wEn, n_trap, n_PCWrite}); exp = 32'({3'd0, 1'b0, 1'b0, 1'b0});
      total++; if (got !== exp) begin bad++; $display("FAIL illegal_nop_fetch got=%h exp=%h", got, exp); end
      tick();
      fetch(32'h0000_2063);
      tick();
      got = 32'({state, trap}); exp = 32'({3'd5, 1'b1});
      total++; if (got !== exp) begin bad++; $display("FAIL illegal_branch_f3 got=%h exp=%h", got, exp); end
      got = 32'(n_state); exp = 32'd0;
      total++; if (got !== exp) begin bad++; $display("FAIL illegal_branch_nop got=%h exp=%h", got, exp); end
      tick();
   endtask

   task automatic test_reset_mid_mem;
      dmem_ready = 1'b0;
      fetch(32'h0000_2083);
      tick(); tick();
      got = 32'({state, MemEn}); exp = 32'({3'd3, 1'b1});
      total++; if (got !== exp) begin bad++; $display("FAIL midmem_pre got=%h exp=%h", got, exp); end
      imem_ready = 1'b1;
      reset_n    = 1'b0;
      #1;
      got = 32'({state, MemEn, MemRW, PCWrite, IRWrite, wEn, ALUop, ImmSel, BSel, trap, PCSel, WBSel});
      exp = 32'd0;
      total++; if (got !== exp) begin bad++; $display("FAIL midmem_async_reset got=%h exp=%h", got, exp); end
      got = 32'({n_state, n_MemEn, n_IRWrite}); exp = 32'd0;
      total++; if (got !== exp) begin bad++; $display("FAIL midmem_async_reset_nop got=%h exp=%h", got, exp); end
      tick();
      imem_ready = 1'b0;
      reset_n    = 1'b1;
      tick(); tick();
      got = 32'({state, IRWrite, MemEn}); exp = 32'({3'd0, 1'b0, 1'b0});
      total++; if (got !== exp) begin bad++; $display("FAIL midmem_wait_fetch got=%h exp=%h", got, exp); end
      imem_ready = 1'b1;
      #1;
      got = 32'({state, IRWrite}); exp = 32'({3'd0, 1'b1});
      total++; if (got !== exp) begin bad++; $display("FAIL midmem_refetch got=%h exp=%h", got, exp); end
      tick();
      imem_ready = 1'b0;
      got = 32'(state); exp = 32'd1;
      total++; if (got !== exp) begin bad++; $display("FAIL midmem_decode got=%h exp=%h", got, exp); end
   endtask

   initial begin
      reset_n     = 1'b0;
      Instruction = 32'd0;
      imem_ready  = 1'b0;
      dmem_ready  = 1'b0;
      BrEq        = 1'b0;
      BrLT        = 1'b0;
      test_reset();
      test_add();
      test_branch(32'h0000_0063, 1'b1, 1'b0, 1'b0, 2'd1);
      test_branch(32'h0000_0063, 1'b0, 1'b0, 1'b0, 2'd0);
      test_branch(32'h0000_1063, 1'b0, 1'b0, 1'b0, 2'd1);
      test_branch(32'h0000_6063, 1'b0, 1'b1, 1'b1, 2'd1);
      test_branch(32'h0000_5063, 1'b0, 1'b1, 1'b0, 2'd0);
      test_alu(32'h4000_0033, 4'd1,  1'b0, 1'b0);
      test_alu(32'h4000_5033, 4'd7,  1'b0, 1'b0);
      test_alu(32'h0000_40B3, 4'd5,  1'b0, 1'b1);
      test_alu(32'h4000_5013, 4'd7,  1'b1, 1'b0);
      test_alu(32'h0000_5013, 4'd6,  1'b1, 1'b0);
      test_alu(32'h4000_0093, 4'd0,  1'b1, 1'b1);
      test_alu(32'h0000_00B7, 4'd10, 1'b1, 1'b1);
      test_jump();
      test_load();
      test_store_timeout();
      test_fetch_timeout();
      test_illegal();
      test_reset_mid_mem();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised multi-cycle RV32I control unit, successor to the single-cycle control_unit. It latches the instruction and sequences FETCH/DECODE/EXEC/MEM/WB/TRAP over several cycles, producing datapath controls per state. It adds memory-ready handshakes, a wait timeout, illegal-opcode trapping and full branch-condition resolution. It sits between the instruction/data memory interfaces and the existing datapath: regfile, ALU, immediate generator and branch comparator.

Parameters:
MEM_TIMEOUT, 16, max cycles spent waiting on imem_ready/dmem_ready before TRAP (>=1)
TRAP_ON_ILLEGAL, 1, 1: illegal opcode/funct3 enters TRAP; 0: treated as NOP (PC+4, no writes)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
Instruction  in  32  instruction word from imem
imem_ready  in  1  Instruction valid this cycle
dmem_ready  in  1  data access complete this cycle
BrEq  in  1  comparator: rs1==rs2
BrLT  in  1  comparator: rs1<rs2 (signedness per BrUn)
ALUop  out  4  0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASSB
ImmSel  out  3  0 I,1 S,2 B,3 U,4 J
ASel  out  1  1 = PC into ALU A
BSel  out  1  1 = immediate into ALU B
BrUn  out  1  unsigned compare
PCSel  out  2  0 PC+4, 1 ALU result, 2 trap vector
PCWrite  out  1  PC register load
IRWrite  out  1  instruction register load
wEn  out  1  regfile write
WBSel  out  2  0 mem, 1 ALU, 2 PC+4
MemEn  out  1  data memory request
MemRW  out  1  1 = store
trap  out  1  one-cycle trap pulse
state  out  3  0 FETCH,1 DECODE,2 EXEC,3 MEM,4 WB,5 TRAP

Behaviour:
- Reset (async, reset_n low): state=FETCH, internal IR=0, wait counter=0; all outputs 0 while reset_n low.
- Controls are combinational from state, IR and the inputs. Datapath selects (ImmSel/ASel/BSel/ALUop/BrUn) are driven from IR in DECODE, EXEC, MEM and WB.
- FETCH:
  - imem_ready=1: IRWrite=1, IR<=Instruction, go DECODE, counter cleared.
  - Otherwise stay and increment counter. When counter reaches MEM_TIMEOUT without ready, go TRAP.
- DECODE (one cycle): classify IR[6:0] into R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Any other opcode, or branch funct3 010/011, is illegal.
  - Illegal with TRAP_ON_ILLEGAL=1: go TRAP. With TRAP_ON_ILLEGAL=0: PCWrite=1, PCSel=0, go FETCH.
  - Legal: go EXEC.
- EXEC:
  - ALUop: R uses funct3 plus funct7[5] (SUB/SRA). I-ALU uses funct3; funct7[5] only for SRAI. LUI uses PASSB. All others use ADD.
  - ASel=1 for BRANCH/JAL/AUIPC. BSel=1 for all but R.
  - BRANCH: BrUn=funct3[1]. Taken = BEQ:BrEq, BNE:!BrEq, BLT/BLTU:BrLT, BGE/BGEU:!BrLT. PCWrite=1, PCSel=taken?1:0, go FETCH.
  - JAL/JALR: PCWrite=1, PCSel=1, go WB. PC is written before WB, so the datapath latches PC+4 for the link value.
  - LOAD/STORE: go MEM.
  - Others: go WB.
- MEM:
  - MemEn=1, MemRW=1 for STORE, counter increments while waiting.
  - dmem_ready=1: STORE gives PCWrite=1, PCSel=0, go FETCH. LOAD goes WB.
  - Timeout at MEM_TIMEOUT: go TRAP. MemEn drops in TRAP.
- WB:
  - wEn=1 unless rd (IR[11:7])==0.
  - WBSel: 0 for LOAD, 2 for JAL/JALR, 1 otherwise.
  - Non-jump: PCWrite=1, PCSel=0. Go FETCH.
- TRAP: trap=1, PCWrite=1, PCSel=2, wEn=0, MemEn=0, one cycle, then FETCH.
- Exactly one of {go FETCH with PCWrite} happens per instruction; PCWrite never asserts twice for one instruction.
- Ready asserted in the same cycle the counter hits MEM_TIMEOUT: ready wins.
- Reset mid-instruction aborts immediately; no partial write survives.

Test Plan:
- ADD 0x00000033, imem_ready=1 always -> FETCH,DECODE,EXEC,WB,FETCH. WB: wEn=0 (rd=0), WBSel=1, ALUop=0, PCWrite=1, PCSel=0.
- BEQ 0x00000063 with BrEq=1 -> EXEC: BrUn=0, ImmSel=2, ASel=1, PCWrite=1, PCSel=1, next FETCH. Same with BrEq=0 -> PCSel=0.
- LW 0x00002083 (rd=1), dmem_ready low for 3 cycles -> MEM held 4 cycles with MemEn=1, MemRW=0. Then WB: wEn=1, WBSel=0.
- SW with dmem_ready never high, MEM_TIMEOUT=16 -> 16 cycles in MEM, then TRAP: trap=1, PCSel=2 for one cycle, then FETCH.
- Opcode 0x0000007F -> DECODE to TRAP when TRAP_ON_ILLEGAL=1. With 0 -> PCWrite=1, PCSel=0, back to FETCH, no wEn.
- reset_n low mid-MEM -> state=0 and all outputs 0 asynchronously. After release, FETCH waits for imem_ready.
